// File: rtl/pulse_shaper.sv
// Turns 1-cycle trig strobes into pulses with a guaranteed high time and low gap, queueing
// requests that arrive mid-pulse. Optional feature macro: RETRIGGER_EN (trig while high extends the pulse).
module pulse_shaper #(
    parameter  int HIGH_COUNT  = 16,
    parameter  int LOW_COUNT   = 16,
    parameter  int QUEUE_DEPTH = 4,
    localparam int PEND_BITS   = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    output logic                 out,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [PEND_BITS-1:0] pending
);

    localparam int MAX_COUNT = (HIGH_COUNT > LOW_COUNT) ? HIGH_COUNT : LOW_COUNT;
    localparam int TW        = $clog2(MAX_COUNT) + 1;

    localparam logic [TW-1:0]        HIGH_LOAD = TW'(HIGH_COUNT - 1);
    localparam logic [TW-1:0]        LOW_LOAD  = TW'(LOW_COUNT - 1);
    localparam logic [PEND_BITS-1:0] PEND_FULL = PEND_BITS'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                 state_reg,    state_next;
    logic [TW-1:0]          timer_reg,    timer_next;
    logic                   out_reg,      out_next;
    logic                   done_reg,     done_next;
    logic                   overflow_reg, overflow_next;
    logic [PEND_BITS-1:0]   pending_reg,  pending_next;

    logic timer_zero;
    logic enq;
    logic deq;
    logic retrig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            out_reg      <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            pending_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            out_reg      <= out_next;
            done_reg     <= done_next;
            overflow_reg <= overflow_next;
            pending_reg  <= pending_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        out_next      = out_reg;
        done_next     = 1'b0;
        overflow_next = 1'b0;
        pending_next  = pending_reg;
        timer_zero    = (timer_reg == '0);
        enq           = 1'b0;
        deq           = 1'b0;
        retrig        = 1'b0;

        case (state_reg)
            IDLE: begin
                // A request seen while idle starts the pulse directly; it never enters the queue.
                out_next = 1'b0;
                if (trig) begin
                    state_next = HIGH;
                    timer_next = HIGH_LOAD;
                    out_next   = 1'b1;
                end
            end

            HIGH: begin
`ifdef RETRIGGER_EN
                retrig = trig;
`else
                enq    = trig;
`endif
                if (retrig) begin
                    timer_next = HIGH_LOAD;
                end else if (timer_zero) begin
                    state_next = GAP;
                    timer_next = LOW_LOAD;
                    out_next   = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end

            GAP: begin
                enq = trig;
                if (timer_zero) begin
                    // A trig landing on the last gap cycle with an empty queue is served
                    // immediately, which nets out the same as enqueue plus dequeue.
                    if ((pending_reg != '0) || trig) begin
                        state_next = HIGH;
                        timer_next = HIGH_LOAD;
                        out_next   = 1'b1;
                        deq        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                timer_next = '0;
                out_next   = 1'b0;
            end
        endcase

        // Simultaneous enqueue and dequeue leaves the count alone, so it can never overflow.
        if (enq && !deq) begin
            if (pending_reg == PEND_FULL) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending_reg + PEND_BITS'(1);
            end
        end else if (deq && !enq) begin
            pending_next = pending_reg - PEND_BITS'(1);
        end
    end

    assign out      = out_reg;
    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign pending  = pending_reg;
    assign busy     = (state_reg != IDLE) || (pending_reg != '0);

endmodule
